// File: rtl/lcd_init_if.sv
// HD44780 init bus: command strobes, data bus and done/reinit handshake.
// master = init sequencer, slave = LCD side / downstream message writer.
interface lcd_init_if;
  logic       reinit;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;
  logic       init_done;

  modport master (
    input  reinit,
    output lcd_rs,
    output lcd_rw,
    output lcd_en,
    output lcd_data,
    output init_done
  );

  modport slave (
    output reinit,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_en,
    input  lcd_data,
    input  init_done
  );
endinterface

// File: rtl/lcd_init_fsm.sv
// HD44780 8-bit power-on init sequencer: fixed 7-command ROM,
// timed enable pulses and per-command waits, then hands bus downstream.
module lcd_init_fsm #(
  parameter int POWERUP_CYCLES    = 2000000,
  parameter int EN_PULSE_CYCLES   = 20,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int LONG_WAIT_CYCLES  = 205000,
  parameter int CLEAR_WAIT_CYCLES = 100000
) (
  input logic         clk,
  input logic         rst_n,
  lcd_init_if.master  bus
);

  localparam int MA = (POWERUP_CYCLES > LONG_WAIT_CYCLES) ?
                      POWERUP_CYCLES : LONG_WAIT_CYCLES;
  localparam int MB = (CLEAR_WAIT_CYCLES > CMD_WAIT_CYCLES) ?
                      CLEAR_WAIT_CYCLES : CMD_WAIT_CYCLES;
  localparam int MC = (MA > MB) ? MA : MB;
  localparam int MX = (MC > EN_PULSE_CYCLES) ? MC : EN_PULSE_CYCLES;
  localparam int CR = $clog2(MX + 1);
  localparam int CW = (CR < 18) ? 18 : CR;

  localparam logic [CW-1:0] PU_LIM  = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LIM  = CW'(EN_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LIM = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LNG_LIM = CW'(LONG_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LIM = CW'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_lim;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic [7:0]    rom_cmd;

  // State, index, counter and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_POWERUP;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Post-command wait: long after first 0x30, longer after clear
  always_comb begin
    wait_lim = CMD_LIM;
    if (idx_q == 3'd0) wait_lim = LNG_LIM;
    if (idx_q == 3'd5) wait_lim = CLR_LIM;
  end

  // Next state: every timed state counts 0..limit then moves on
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      S_POWERUP: begin
        if (cnt_q == PU_LIM) begin
          state_d = S_SETUP;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = '0;
      end
      S_PULSE: begin
        if (cnt_q == EN_LIM) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_lim) begin
          cnt_d = '0;
          if (idx_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        cnt_d = '0;
        if (bus.reinit) state_d = S_POWERUP;
      end
      default: begin
        state_d = S_POWERUP;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Command ROM, looked up with the index being entered
  always_comb begin
    rom_cmd = 8'h00;
    unique case (idx_d)
      3'd0:    rom_cmd = 8'h30;
      3'd1:    rom_cmd = 8'h30;
      3'd2:    rom_cmd = 8'h30;
      3'd3:    rom_cmd = 8'h38;
      3'd4:    rom_cmd = 8'h0C;
      3'd5:    rom_cmd = 8'h01;
      3'd6:    rom_cmd = 8'h06;
      default: rom_cmd = 8'h00;
    endcase
  end

  // Outputs follow the state being entered; data/rs latch only in setup
  always_comb begin
    rs_d   = rs_q;
    data_d = data_q;
    en_d   = (state_d == S_PULSE);
    done_d = (state_d == S_DONE);
    if (state_d == S_SETUP) begin
      rs_d   = 1'b0;
      data_d = rom_cmd;
    end
  end

  assign bus.lcd_rs    = rs_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = en_q;
  assign bus.lcd_data  = data_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_lcd_init_fsm.sv
// Directed bench for lcd_init_fsm: latency, command bytes, pulse
// widths/gaps, reinit in and out of done, async reset mid-pulse.
module tb_lcd_init_fsm;
  localparam int PU  = 10;
  localparam int ENP = 2;
  localparam int CMD = 5;
  localparam int LNG = 8;
  localparam int CLR = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  lcd_init_if bus();

  lcd_init_fsm #(
    .POWERUP_CYCLES   (PU),
    .EN_PULSE_CYCLES  (ENP),
    .CMD_WAIT_CYCLES  (CMD),
    .LONG_WAIT_CYCLES (LNG),
    .CLEAR_WAIT_CYCLES(CLR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int edges, nr, nf;
  int rise_e [8];
  int fall_e [8];
  logic [7:0] cap_d [8];
  logic cap_rs [8];
  logic cap_rw [8];
  logic [7:0] rom [7] = '{8'h30, 8'h30, 8'h30, 8'h38,
                          8'h0C, 8'h01, 8'h06};
  int gap_x [6] = '{9, 6, 6, 6, 6, 13};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic run_seq(input int reinit_at, input int stop_rise);
    logic pe;
    edges = 0;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      rise_e[i] = 0;
      fall_e[i] = 0;
      cap_d[i]  = 8'h00;
      cap_rs[i] = 1'b1;
      cap_rw[i] = 1'b1;
    end
    pe = bus.lcd_en;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.lcd_en && !pe && nr < 8) begin
        rise_e[nr] = edges;
        cap_d[nr]  = bus.lcd_data;
        cap_rs[nr] = bus.lcd_rs;
        cap_rw[nr] = bus.lcd_rw;
        nr++;
      end
      if (!bus.lcd_en && pe && nf < 8) begin
        fall_e[nf] = edges;
        nf++;
      end
      pe = bus.lcd_en;
      if (reinit_at > 0 && edges == reinit_at - 1) bus.reinit = 1'b1;
      if (reinit_at > 0 && edges == reinit_at) bus.reinit = 1'b0;
      if (bus.init_done) break;
      if (stop_rise > 0 && nr == stop_rise) break;
    end
  endtask

  task automatic check_seq(input string t);
    check({t, ".done_lat"}, edges, 76);
    check({t, ".npulse"}, nr, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("%s.data%0d", t, i), cap_d[i], rom[i]);
      check($sformatf("%s.rs%0d", t, i), cap_rs[i], 0);
      check($sformatf("%s.rw%0d", t, i), cap_rw[i], 0);
      check($sformatf("%s.hi%0d", t, i), fall_e[i] - rise_e[i], ENP);
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("%s.gap%0d", t, i),
            rise_e[i+1] - fall_e[i], gap_x[i]);
  endtask

  initial begin
    bus.reinit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst.en", bus.lcd_en, 0);
    check("rst.done", bus.init_done, 0);
    check("rst.data", bus.lcd_data, 8'h00);
    check("rst.rs", bus.lcd_rs, 0);
    check("rst.rw", bus.lcd_rw, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.hold_en", bus.lcd_en, 0);
    check("rst.hold_done", bus.init_done, 0);

    @(negedge clk) rst_n = 1'b1;
    run_seq(0, 0);
    check_seq("first");

    repeat (3) @(posedge clk);
    #1;
    check("done.hold", bus.init_done, 1);
    check("done.en", bus.lcd_en, 0);
    check("done.data", bus.lcd_data, 8'h06);
    check("done.rs", bus.lcd_rs, 0);

    @(negedge clk) bus.reinit = 1'b1;
    @(posedge clk);
    #1;
    bus.reinit = 1'b0;
    check("reinit.done_low", bus.init_done, 0);
    run_seq(0, 0);
    check_seq("reinit");

    @(negedge clk) bus.reinit = 1'b1;
    @(posedge clk);
    #1;
    bus.reinit = 1'b0;
    run_seq(30, 0);
    check_seq("ignored");

    @(negedge clk) bus.reinit = 1'b1;
    @(posedge clk);
    #1;
    bus.reinit = 1'b0;
    run_seq(0, 4);
    check("mid.en_idx3", bus.lcd_en, 1);
    check("mid.data_idx3", bus.lcd_data, 8'h38);
    rst_n = 1'b0;
    #1;
    check("mid.en_async", bus.lcd_en, 0);
    check("mid.done_async", bus.init_done, 0);
    check("mid.data_async", bus.lcd_data, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    run_seq(0, 0);
    check_seq("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_init_fsm.md
LCD_INIT_FSM -- requirements
Module: lcd_init_fsm

Interface
REQ-001 SHALL provide parameter POWERUP_CYCLES, default 2000000, power-on delay before first command (40 ms at 50 MHz).
REQ-002 SHALL provide parameter EN_PULSE_CYCLES, default 20, lcd_en high time per command.
REQ-003 SHALL provide parameter CMD_WAIT_CYCLES, default 2500, post-command wait for ordinary commands (50 us).
REQ-004 SHALL provide parameter LONG_WAIT_CYCLES, default 205000, wait after first 0x30 (4.1 ms).
REQ-005 SHALL provide parameter CLEAR_WAIT_CYCLES, default 100000, wait after 0x01 clear (2 ms).
REQ-006 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port reinit, input, 1, single-cycle request to rerun the sequence.
REQ-009 SHALL have port lcd_rs, output, 1, HD44780 register select, reg.
REQ-010 SHALL have port lcd_rw, output, 1, HD44780 read/write, reg.
REQ-011 SHALL have port lcd_en, output, 1, HD44780 enable strobe, reg.
REQ-012 SHALL have port lcd_data, output, 8, HD44780 data bus, reg.
REQ-013 SHALL have port init_done, output, 1, level high once the sequence completes; feeds the downstream message writer.

Function
REQ-014 SHALL implement states S_POWERUP, S_SETUP, S_PULSE, S_WAIT, S_DONE, plus a 3-bit cmd_index (0..6) and one shared delay counter of at least 18 bits.
REQ-015 SHALL issue this fixed 8-bit-mode command ROM in order: idx0 0x30, idx1 0x30, idx2 0x30, idx3 0x38, idx4 0x0C, idx5 0x01, idx6 0x06.
REQ-016 SHALL select the post-command wait by index: idx0 LONG_WAIT_CYCLES, idx5 CLEAR_WAIT_CYCLES, all others CMD_WAIT_CYCLES.
REQ-017 S_POWERUP SHALL hold all outputs at reset values for exactly POWERUP_CYCLES cycles, then enter S_SETUP with cmd_index=0.
REQ-018 S_SETUP SHALL last exactly 1 cycle: lcd_rs<=0, lcd_data<=ROM[cmd_index], lcd_en stays 0.
REQ-019 S_PULSE SHALL hold lcd_en=1 for exactly EN_PULSE_CYCLES consecutive cycles, then drop to 0 on entering S_WAIT.
REQ-020 S_WAIT SHALL last the selected wait count with lcd_en=0; then if cmd_index<6 increment it and enter S_SETUP, otherwise enter S_DONE.
REQ-021 lcd_data and lcd_rs SHALL remain stable from S_SETUP through the end of S_WAIT of the same command.
REQ-022 lcd_rw SHALL be 0 at all times; busy-flag reads are not supported.
REQ-023 init_done SHALL go high on the cycle S_DONE is entered and stay high while in S_DONE.
REQ-024 In S_DONE, lcd_en SHALL be 0 and lcd_data/lcd_rs SHALL be undriven-by-intent (hold last value) so the downstream writer owns the bus.
REQ-025 reinit asserted while in S_DONE SHALL clear init_done on the next edge, zero the counter, and enter S_POWERUP.
REQ-026 reinit asserted in any state other than S_DONE SHALL be ignored.
REQ-027 Per-command cost SHALL be 1 + EN_PULSE_CYCLES + wait cycles; no extra idle cycles between commands.

Reset
REQ-028 rst_n low SHALL immediately force state=S_POWERUP, cmd_index=0, counter=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_data=0x00, init_done=0.
REQ-029 Reset asserted mid-sequence (including during lcd_en high) SHALL drop lcd_en asynchronously, and the sequence SHALL restart from the full power-up delay.

Verification
REQ-030 Params POWERUP=10, EN=2, CMD=5, LONG=8, CLEAR=12; release reset -> init_done rises exactly 76 clk edges later (10 + 7*3 + 45).
REQ-031 Same run, capture lcd_data on each lcd_en rising edge -> sequence 0x30,0x30,0x30,0x38,0x0C,0x01,0x06 with lcd_rs=0 and lcd_rw=0 every time.
REQ-032 Measure each lcd_en pulse -> high exactly 2 cycles; gap after 1st pulse 9 cycles (8 + 1 setup), after 6th 13 cycles, others 6 cycles.
REQ-033 Pulse reinit in S_DONE -> init_done low next cycle, full 76-cycle sequence repeats; pulse reinit at cycle 30 -> no effect, done still at 76.
REQ-034 Assert rst_n low while lcd_en=1 during idx3 -> lcd_en, init_done, lcd_data go to 0 without a clock edge; after release -> done 76 cycles later.
